// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared encodings for the shift-datapath sequencer: operation codes,
// shift-amount mux selects, shift-input mux selects, shift-register control
// codes and FSM states, plus the combinational operation decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

    localparam int SHAMT_W_DEF = 5;
    localparam int OPC_W_DEF   = 3;
    localparam int SHCTL_W_DEF = 3;

    typedef enum logic [2:0] {
        OP_SLL     = 3'b000,
        OP_SRL     = 3'b001,
        OP_SRA     = 3'b010,
        OP_SLLV    = 3'b011,
        OP_SRLV    = 3'b100,
        OP_SRAV    = 3'b101,
        OP_LUI     = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        AMT_SHAMT = 2'd0,   // instruction shamt field
        AMT_RS    = 2'd1,   // rs[4:0]
        AMT_C16   = 2'd2,   // constant 16
        AMT_C24   = 2'd3    // constant 24
    } shamt_sel_e;

    typedef enum logic {
        SRC_RT    = 1'b0,
        SRC_IMM16 = 1'b1
    } src_sel_e;

    typedef enum logic [2:0] {
        SHCTL_HOLD    = 3'b000,
        SHCTL_LOAD    = 3'b001,
        SHCTL_LEFT    = 3'b010,
        SHCTL_RIGHT_L = 3'b011,
        SHCTL_RIGHT_A = 3'b100
    } shctl_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_WB    = 2'd3
    } state_e;

    typedef struct packed {
        shamt_sel_e shamt_sel;
        src_sel_e   src_sel;
        shctl_e     shift_code;
        logic       illegal;
    } op_dec_t;

    // Maps an operation to its amount source, input source and shift direction.
    function automatic op_dec_t decode_op(input op_e op);
        op_dec_t d;
        d = '{shamt_sel: AMT_SHAMT, src_sel: SRC_RT, shift_code: SHCTL_LEFT, illegal: 1'b0};
        case (op)
            OP_SLL:  d.shift_code = SHCTL_LEFT;
            OP_SRL:  d.shift_code = SHCTL_RIGHT_L;
            OP_SRA:  d.shift_code = SHCTL_RIGHT_A;
            OP_SLLV: begin d.shamt_sel = AMT_RS; d.shift_code = SHCTL_LEFT;    end
            OP_SRLV: begin d.shamt_sel = AMT_RS; d.shift_code = SHCTL_RIGHT_L; end
            OP_SRAV: begin d.shamt_sel = AMT_RS; d.shift_code = SHCTL_RIGHT_A; end
            // LUI is the immediate shifted left by a constant 16.
            OP_LUI:  begin d.shamt_sel = AMT_C16; d.src_sel = SRC_IMM16; d.shift_code = SHCTL_LEFT; end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multicycle controller for the shift datapath. Accepts one shift-class
// operation and steps the shift register through LOAD -> SHIFT -> WB,
// skipping SHIFT when the selected shift amount is zero.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        request pulse, sampled only when idle
//   op           operation code (SLL/SRL/SRA/SLLV/SRLV/SRAV/LUI, 111 illegal)
//   shamt_value  current output of the shift-amount mux (zero test only)
//   shamt_sel    shift-amount mux select
//   src_sel      shift-input mux select
//   shift_ctl    shift-register control code
//   reg_write    register-file write strobe for the shifter result
//   busy         operation in flight (LOAD/SHIFT)
//   done         one-cycle completion pulse
//   err          one-cycle illegal-operation pulse
//
// Build option: define SHIFT_SEQ_B2B_EN to also accept a new request in the
// WB cycle (back-to-back issue). Without it, start in WB is ignored.
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int SHAMT_W = SHAMT_W_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int SHCTL_W = SHCTL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OPC_W-1:0]   op,
    input  logic [SHAMT_W-1:0] shamt_value,
    output logic [1:0]         shamt_sel,
    output logic               src_sel,
    output logic [SHCTL_W-1:0] shift_ctl,
    output logic               reg_write,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e  state_q;
    shctl_e  shift_code_q;   // direction of the accepted op, applied in SHIFT
    op_dec_t dec_in;
    logic    accept_window;

    assign dec_in = decode_op(op_e'(op));

`ifdef SHIFT_SEQ_B2B_EN
    assign accept_window = (state_q == S_IDLE) || (state_q == S_WB);
`else
    assign accept_window = (state_q == S_IDLE);
`endif

    // NOTE: every output is a flop updated with non-blocking assignments, so
    // the value written here becomes visible in the cycle of the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_code_q <= SHCTL_HOLD;
            shamt_sel    <= '0;
            src_sel      <= 1'b0;
            shift_ctl    <= '0;
            reg_write    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            reg_write <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    shift_ctl <= SHCTL_W'(SHCTL_HOLD);
                    busy      <= 1'b0;
                end
                S_LOAD: begin
                    if (shamt_value != '0) begin
                        state_q   <= S_SHIFT;
                        shift_ctl <= SHCTL_W'(shift_code_q);
                    end else begin
                        state_q   <= S_WB;
                        shift_ctl <= SHCTL_W'(SHCTL_HOLD);
                        reg_write <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    state_q   <= S_WB;
                    shift_ctl <= SHCTL_W'(SHCTL_HOLD);
                    reg_write <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                S_WB: begin
                    state_q   <= S_IDLE;
                    shift_ctl <= SHCTL_W'(SHCTL_HOLD);
                    busy      <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase

            // Acceptance overrides the state-specific defaults above; the
            // selectors change only here, so they hold for the whole operation.
            if (start && accept_window) begin
                if (dec_in.illegal) begin
                    state_q   <= S_IDLE;
                    shift_ctl <= SHCTL_W'(SHCTL_HOLD);
                    busy      <= 1'b0;
                    err       <= 1'b1;
                    done      <= 1'b1;
                end else begin
                    state_q      <= S_LOAD;
                    shamt_sel    <= dec_in.shamt_sel;
                    src_sel      <= dec_in.src_sel;
                    shift_code_q <= dec_in.shift_code;
                    shift_ctl    <= SHCTL_W'(SHCTL_LOAD);
                    busy         <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Self-checking bench for shift_sequencer. Expected per-cycle output words are
// queued when stimulus is driven and compared each cycle on the falling edge.
// Output word layout: {shamt_sel[1:0], src_sel, shift_ctl[2:0], reg_write,
// busy, done, err}.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

    typedef struct packed {
        logic [1:0] sel;
        logic       src;
        logic [2:0] ctl;
        logic       rw;
        logic       busy;
        logic       done;
        logic       err;
    } out_t;

    typedef struct {
        string name;
        out_t  val;
    } exp_t;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [4:0] shamt;
        logic [1:0] sel;
        logic       src;
        logic [2:0] code;
        logic       illegal;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [4:0] shamt_value;
    logic [1:0] shamt_sel;
    logic       src_sel;
    logic [2:0] shift_ctl;
    logic       reg_write;
    logic       busy;
    logic       done;
    logic       err;

    out_t act;
    assign act = '{sel: shamt_sel, src: src_sel, ctl: shift_ctl, rw: reg_write,
                   busy: busy, done: done, err: err};

    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    exp_t exp_q[$];
    logic [1:0] last_sel = 2'd0;
    logic       last_src = 1'b0;

    shift_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .shamt_value (shamt_value),
        .shamt_sel   (shamt_sel),
        .src_sel     (src_sel),
        .shift_ctl   (shift_ctl),
        .reg_write   (reg_write),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(logic [1:0] sel, logic src, logic [2:0] ctl,
                                logic rw, logic bsy, logic dn, logic er);
        return '{sel: sel, src: src, ctl: ctl, rw: rw, busy: bsy, done: dn, err: er};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic push(input string name, input out_t val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Advance one cycle; compare the oldest queued expectation, if any.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.name, 32'(act), 32'(e.val));
        end
    endtask

    task automatic drain();
        while (exp_q.size() != 0) tick();
    endtask

    // Drives one request and queues the cycle-by-cycle trace it should produce.
    task automatic run_vec(input vec_t v);
        start       = 1'b1;
        op          = v.op;
        shamt_value = v.shamt;
        if (v.illegal) begin
            push({v.name, ".c1"}, mk(last_sel, last_src, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1));
            push({v.name, ".c2"}, mk(last_sel, last_src, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        end else begin
            push({v.name, ".load"}, mk(v.sel, v.src, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
            if (v.shamt != 5'd0)
                push({v.name, ".shift"}, mk(v.sel, v.src, v.code, 1'b0, 1'b1, 1'b0, 1'b0));
            push({v.name, ".wb"},   mk(v.sel, v.src, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0));
            push({v.name, ".idle"}, mk(v.sel, v.src, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
            last_sel = v.sel;
            last_src = v.src;
        end
        tick();
        start = 1'b0;
        drain();
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{"sll4",   3'b000, 5'd4,  2'd0, 1'b0, 3'b010, 1'b0};
        vecs[1]  = '{"srl7",   3'b001, 5'd7,  2'd0, 1'b0, 3'b011, 1'b0};
        vecs[2]  = '{"sra31",  3'b010, 5'd31, 2'd0, 1'b0, 3'b100, 1'b0};
        vecs[3]  = '{"sllv1",  3'b011, 5'd1,  2'd1, 1'b0, 3'b010, 1'b0};
        vecs[4]  = '{"srlv0",  3'b100, 5'd0,  2'd1, 1'b0, 3'b011, 1'b0};
        vecs[5]  = '{"srav0",  3'b101, 5'd0,  2'd1, 1'b0, 3'b100, 1'b0};
        vecs[6]  = '{"srav9",  3'b101, 5'd9,  2'd1, 1'b0, 3'b100, 1'b0};
        vecs[7]  = '{"lui16",  3'b110, 5'd16, 2'd2, 1'b1, 3'b010, 1'b0};
        vecs[8]  = '{"ill",    3'b111, 5'd5,  2'd0, 1'b0, 3'b000, 1'b1};
        vecs[9]  = '{"sll0",   3'b000, 5'd0,  2'd0, 1'b0, 3'b010, 1'b0};
        vecs[10] = '{"ill_z",  3'b111, 5'd0,  2'd0, 1'b0, 3'b000, 1'b1};

        reset       = 1'b1;
        start       = 1'b0;
        op          = 3'b000;
        shamt_value = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(act), 32'(mk(2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0)));
        reset = 1'b0;
        tick();
        check("post_reset_idle", 32'(act), 32'(mk(2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0)));

        // Table-driven single operations.
        for (int i = 0; i < 11; i++) begin
            done_seen = 0;
            run_vec(vecs[i]);
            check({vecs[i].name, ".done_count"}, 32'(done_seen), 32'd1);
        end

        // SRLV accepted; a second start during SHIFT is dropped.
        done_seen   = 0;
        start       = 1'b1;
        op          = 3'b100;
        shamt_value = 5'd3;
        push("busy_c1", mk(2'd1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
        push("busy_c2", mk(2'd1, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0));
        push("busy_c3", mk(2'd1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0));
        push("busy_c4", mk(2'd1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        push("busy_c5", mk(2'd1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        op    = 3'b000;
        tick();
        start = 1'b0;
        drain();
        check("busy_done_count", 32'(done_seen), 32'd1);
        last_sel = 2'd1;
        last_src = 1'b0;

        // SRLV accepted; a new SLL presented during WB.
        done_seen   = 0;
        start       = 1'b1;
        op          = 3'b100;
        shamt_value = 5'd3;
        push("wb_c1", mk(2'd1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
        push("wb_c2", mk(2'd1, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0));
        push("wb_c3", mk(2'd1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0));
`ifdef SHIFT_SEQ_B2B_EN
        push("wb_c4", mk(2'd0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
        push("wb_c5", mk(2'd0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0));
        push("wb_c6", mk(2'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0));
        push("wb_c7", mk(2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        push("wb_c4", mk(2'd1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        push("wb_c5", mk(2'd1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        op    = 3'b000;
        tick();
        start = 1'b0;
        drain();
`ifdef SHIFT_SEQ_B2B_EN
        check("wb_done_count", 32'(done_seen), 32'd2);
        last_sel = 2'd0;
`else
        check("wb_done_count", 32'(done_seen), 32'd1);
        last_sel = 2'd1;
`endif

        // SRA accepted; reset asserted during SHIFT drops the operation.
        done_seen   = 0;
        start       = 1'b1;
        op          = 3'b010;
        shamt_value = 5'd5;
        push("rst_c1", mk(2'd0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
        push("rst_c2", mk(2'd0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        push("rst_c3", mk(2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        reset = 1'b0;
        push("rst_c4", mk(2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        check("rst_done_count", 32'(done_seen), 32'd0);
        last_sel = 2'd0;
        last_src = 1'b0;

        // A fresh operation after the aborted one completes normally.
        done_seen = 0;
        run_vec('{"after_rst_sll", 3'b000, 5'd2, 2'd0, 1'b0, 3'b010, 1'b0});
        check("after_rst_done_count", 32'(done_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
